// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
// Bundles the two requester handshakes and the SRAM controller connection of
// the port arbiter.
//   Requester side : req0/req1, we_n0/we_n1, addr0/addr1, wdata0/wdata1 (to arbiter)
//                    ack0/ack1, rdata0/rdata1, busy, grant_id            (from arbiter)
//   Controller side: SRAM_start, SRAM_address, SRAM_write_data, SRAM_we_n (from arbiter)
//                    SRAM_read_data                                      (to arbiter)
// Modports:
//   slave  - the arbiter's view
//   master - the view of whatever drives the requests and models the controller
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we_n0;
    logic              we_n1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic              grant_id;
    logic              SRAM_start;
    logic [ADDR_W-1:0] SRAM_address;
    logic [DATA_W-1:0] SRAM_write_data;
    logic              SRAM_we_n;
    logic [DATA_W-1:0] SRAM_read_data;

    modport slave (
        input  req0, req1, we_n0, we_n1, addr0, addr1, wdata0, wdata1,
        input  SRAM_read_data,
        output ack0, ack1, rdata0, rdata1, busy, grant_id,
        output SRAM_start, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport master (
        output req0, req1, we_n0, we_n1, addr0, addr1, wdata0, wdata1,
        output SRAM_read_data,
        input  ack0, ack1, rdata0, rdata1, busy, grant_id,
        input  SRAM_start, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Two-requester round-robin arbiter in front of the single-port SRAM
// controller. One requester owns the controller at a time; the winner's
// address, write data and we_n are latched at grant and held on the SRAM_*
// outputs while SRAM_start is high for ACCESS_CYCLES cycles. A registered
// one-cycle ack closes each access, and read results land in the owner's
// rdata register.
// Ports:
//   Clock_50 - system clock, rising edge
//   Resetn   - synchronous reset, active high
//   bus      - requester handshakes and SRAM controller signals (slave view)
module sram_port_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                 Clock_50,
    input  logic                 Resetn,
    sram_port_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic              grant_id;
    logic              sram_start;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_write_data;
    logic              sram_we_n;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    logic              any_req;
    logic              winner;
    logic              win_we_n;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // On a tie the port that did not win last time goes next; with a single
    // requester that requester wins (req1 alone selects 1, req0 alone 0).
    always_comb begin
        any_req   = bus.req0 | bus.req1;
        winner    = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
        win_we_n  = winner ? bus.we_n1  : bus.we_n0;
        win_addr  = winner ? bus.addr1  : bus.addr0;
        win_wdata = winner ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge Clock_50) begin
        if (Resetn) begin
            state           <= S_IDLE;
            cnt             <= '0;
            last_grant      <= 1'b1;
            grant_id        <= 1'b0;
            sram_start      <= 1'b0;
            sram_address    <= '0;
            sram_write_data <= '0;
            sram_we_n       <= 1'b1;
            ack0            <= 1'b0;
            ack1            <= 1'b0;
            rdata0          <= '0;
            rdata1          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state           <= S_ACCESS;
                        cnt             <= '0;
                        grant_id        <= winner;
                        last_grant      <= winner;
                        sram_start      <= 1'b1;
                        sram_address    <= win_addr;
                        sram_write_data <= win_wdata;
                        sram_we_n       <= win_we_n;
                    end
                end
                S_ACCESS: begin
                    if (cnt < LAST_CNT) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        // Last access cycle: the controller's read data is
                        // valid now, so capture it alongside the ack.
                        state      <= S_DONE;
                        sram_start <= 1'b0;
                        if (grant_id) begin
                            ack1 <= 1'b1;
                            if (sram_we_n) rdata1 <= bus.SRAM_read_data;
                        end else begin
                            ack0 <= 1'b1;
                            if (sram_we_n) rdata0 <= bus.SRAM_read_data;
                        end
                    end
                end
                S_DONE: begin
                    // Requests are deliberately ignored here so a requester
                    // has this cycle to drop req after seeing its ack.
                    state     <= S_IDLE;
                    ack0      <= 1'b0;
                    ack1      <= 1'b0;
                    sram_we_n <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy            = (state != S_IDLE);
    assign bus.grant_id        = grant_id;
    assign bus.ack0            = ack0;
    assign bus.ack1            = ack1;
    assign bus.rdata0          = rdata0;
    assign bus.rdata1          = rdata1;
    assign bus.SRAM_start      = sram_start;
    assign bus.SRAM_address    = sram_address;
    assign bus.SRAM_write_data = sram_write_data;
    assign bus.SRAM_we_n       = sram_we_n;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Directed-vector bench for sram_port_arbiter (ACCESS_CYCLES = 2). Inputs are
// driven and outputs sampled on the falling edge of Clock_50. With a request
// granted at rising edge t, the falling-edge samples after t and t+1 see
// SRAM_start high, the sample after t+2 sees the ack, and the sample after
// t+3 sees the arbiter back in IDLE.
module tb_sram_port_arbiter;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus_if ();

    sram_port_arbiter #(
        .ADDR_W(20),
        .DATA_W(16),
        .ACCESS_CYCLES(2)
    ) dut (
        .Clock_50(clk),
        .Resetn(rst),
        .bus(bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Reset with req0 held: nothing may start, then port 0 wins right away.
    task automatic test_reset();
        rst = 1'b1;
        bus_if.req0 = 1'b1; bus_if.we_n0 = 1'b0;
        bus_if.addr0 = 20'h00005; bus_if.wdata0 = 16'h5555;
        step(); step();
        vectors++; if (bus_if.SRAM_start !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_start: got %h expected 0", bus_if.SRAM_start); end
        vectors++; if (bus_if.SRAM_we_n !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_we_n: got %h expected 1", bus_if.SRAM_we_n); end
        vectors++; if (bus_if.SRAM_address !== 20'h0) begin miscompares++; $display("[TB] FAIL rst_addr: got %h expected 0", bus_if.SRAM_address); end
        vectors++; if (bus_if.SRAM_write_data !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_wdata: got %h expected 0", bus_if.SRAM_write_data); end
        vectors++; if ({bus_if.ack0, bus_if.ack1} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_acks: got %b expected 00", {bus_if.ack0, bus_if.ack1}); end
        vectors++; if (bus_if.rdata0 !== 16'h0 || bus_if.rdata1 !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_rdata: got %h/%h expected 0/0", bus_if.rdata0, bus_if.rdata1); end
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %h expected 0", bus_if.busy); end
        vectors++; if (bus_if.grant_id !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_grant: got %h expected 0", bus_if.grant_id); end
        rst = 1'b0;
        step();
        vectors++; if (bus_if.SRAM_start !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_first_start: got %h expected 1", bus_if.SRAM_start); end
        vectors++; if (bus_if.grant_id !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_first_grant: got %h expected 0", bus_if.grant_id); end
        vectors++; if (bus_if.SRAM_address !== 20'h00005) begin miscompares++; $display("[TB] FAIL rst_first_addr: got %h expected 00005", bus_if.SRAM_address); end
        bus_if.req0 = 1'b0;
        step(); step();
        vectors++; if (bus_if.ack0 !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_first_ack0: got %h expected 1", bus_if.ack0); end
        step();
    endtask

    // Single write from port 0; inputs are scrambled after grant to prove latching.
    task automatic test_single_write();
        bus_if.req0 = 1'b1; bus_if.we_n0 = 1'b0;
        bus_if.addr0 = 20'h00012; bus_if.wdata0 = 16'hBEEF;
        step();
        vectors++; if (bus_if.SRAM_start !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_start_c1: got %h expected 1", bus_if.SRAM_start); end
        vectors++; if (bus_if.SRAM_address !== 20'h00012) begin miscompares++; $display("[TB] FAIL wr_addr_c1: got %h expected 00012", bus_if.SRAM_address); end
        vectors++; if (bus_if.SRAM_write_data !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL wr_wdata_c1: got %h expected beef", bus_if.SRAM_write_data); end
        vectors++; if (bus_if.SRAM_we_n !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_we_n_c1: got %h expected 0", bus_if.SRAM_we_n); end
        vectors++; if (bus_if.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_busy_c1: got %h expected 1", bus_if.busy); end
        vectors++; if (bus_if.ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ack0_c1: got %h expected 0", bus_if.ack0); end
        bus_if.addr0 = 20'h55555; bus_if.wdata0 = 16'h0000; bus_if.we_n0 = 1'b1;
        step();
        vectors++; if (bus_if.SRAM_start !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_start_c2: got %h expected 1", bus_if.SRAM_start); end
        vectors++; if (bus_if.SRAM_address !== 20'h00012) begin miscompares++; $display("[TB] FAIL wr_addr_c2: got %h expected 00012", bus_if.SRAM_address); end
        vectors++; if (bus_if.SRAM_write_data !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL wr_wdata_c2: got %h expected beef", bus_if.SRAM_write_data); end
        vectors++; if (bus_if.SRAM_we_n !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_we_n_c2: got %h expected 0", bus_if.SRAM_we_n); end
        vectors++; if (bus_if.ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ack0_c2: got %h expected 0", bus_if.ack0); end
        step();
        vectors++; if (bus_if.SRAM_start !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_start_c3: got %h expected 0", bus_if.SRAM_start); end
        vectors++; if ({bus_if.ack0, bus_if.ack1} !== 2'b10) begin miscompares++; $display("[TB] FAIL wr_ack_c3: got %b expected 10", {bus_if.ack0, bus_if.ack1}); end
        vectors++; if (bus_if.rdata0 !== 16'h0) begin miscompares++; $display("[TB] FAIL wr_rdata0: got %h expected 0", bus_if.rdata0); end
        bus_if.req0 = 1'b0;
        step();
        vectors++; if (bus_if.ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ack0_c4: got %h expected 0", bus_if.ack0); end
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_busy_c4: got %h expected 0", bus_if.busy); end
        vectors++; if (bus_if.SRAM_we_n !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_we_n_c4: got %h expected 1", bus_if.SRAM_we_n); end
        step();
        vectors++; if (bus_if.SRAM_start !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_no_regrant: got %h expected 0", bus_if.SRAM_start); end
    endtask

    // Single read from port 1 at the top address.
    task automatic test_single_read();
        bus_if.req1 = 1'b1; bus_if.we_n1 = 1'b1; bus_if.addr1 = 20'hFFFFF;
        bus_if.SRAM_read_data = 16'h1234;
        step();
        vectors++; if (bus_if.grant_id !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_grant: got %h expected 1", bus_if.grant_id); end
        vectors++; if (bus_if.SRAM_address !== 20'hFFFFF) begin miscompares++; $display("[TB] FAIL rd_addr: got %h expected fffff", bus_if.SRAM_address); end
        vectors++; if (bus_if.SRAM_we_n !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_we_n: got %h expected 1", bus_if.SRAM_we_n); end
        step();
        vectors++; if (bus_if.rdata1 !== 16'h0) begin miscompares++; $display("[TB] FAIL rd_rdata1_early: got %h expected 0", bus_if.rdata1); end
        step();
        vectors++; if ({bus_if.ack0, bus_if.ack1} !== 2'b01) begin miscompares++; $display("[TB] FAIL rd_ack: got %b expected 01", {bus_if.ack0, bus_if.ack1}); end
        vectors++; if (bus_if.rdata1 !== 16'h1234) begin miscompares++; $display("[TB] FAIL rd_rdata1: got %h expected 1234", bus_if.rdata1); end
        vectors++; if (bus_if.rdata0 !== 16'h0) begin miscompares++; $display("[TB] FAIL rd_rdata0: got %h expected 0", bus_if.rdata0); end
        bus_if.req1 = 1'b0;
        bus_if.SRAM_read_data = 16'hDEAD;
        step();
        vectors++; if (bus_if.ack1 !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_ack1_end: got %h expected 0", bus_if.ack1); end
        vectors++; if (bus_if.rdata1 !== 16'h1234) begin miscompares++; $display("[TB] FAIL rd_rdata1_hold: got %h expected 1234", bus_if.rdata1); end
    endtask

    // Both ports request continuously: grants alternate starting with port 0.
    task automatic test_contention();
        logic exp_id;
        bus_if.req0 = 1'b1; bus_if.we_n0 = 1'b0; bus_if.addr0 = 20'h00100; bus_if.wdata0 = 16'hA5A5;
        bus_if.req1 = 1'b1; bus_if.we_n1 = 1'b1; bus_if.addr1 = 20'h00200;
        bus_if.SRAM_read_data = 16'hABCD;
        for (int a = 0; a < 4; a++) begin
            exp_id = a[0];
            step();
            vectors++; if (bus_if.grant_id !== exp_id) begin miscompares++; $display("[TB] FAIL cont_grant%0d: got %h expected %h", a, bus_if.grant_id, exp_id); end
            vectors++; if (bus_if.SRAM_address !== (exp_id ? 20'h00200 : 20'h00100)) begin miscompares++; $display("[TB] FAIL cont_addr%0d: got %h", a, bus_if.SRAM_address); end
            vectors++; if (bus_if.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL cont_busy%0d: got %h expected 1", a, bus_if.busy); end
            step(); step();
            vectors++; if ({bus_if.ack0, bus_if.ack1} !== (exp_id ? 2'b01 : 2'b10)) begin miscompares++; $display("[TB] FAIL cont_ack%0d: got %b", a, {bus_if.ack0, bus_if.ack1}); end
            if (a == 3) begin
                bus_if.req0 = 1'b0;
                bus_if.req1 = 1'b0;
            end
            step();
            vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL cont_gap%0d: got %h expected 0", a, bus_if.busy); end
        end
        step();
        vectors++; if (bus_if.busy !== 1'b0 || bus_if.SRAM_start !== 1'b0) begin miscompares++; $display("[TB] FAIL cont_end: got %h/%h expected 0/0", bus_if.busy, bus_if.SRAM_start); end
        vectors++; if (bus_if.rdata1 !== 16'hABCD) begin miscompares++; $display("[TB] FAIL cont_rdata1: got %h expected abcd", bus_if.rdata1); end
    endtask

    // Reset lands in the middle of a read: no ack, no rdata update.
    task automatic test_reset_mid_access();
        bus_if.req1 = 1'b1; bus_if.we_n1 = 1'b1; bus_if.addr1 = 20'h00777;
        bus_if.SRAM_read_data = 16'h7777;
        step();
        vectors++; if (bus_if.SRAM_start !== 1'b1) begin miscompares++; $display("[TB] FAIL rma_started: got %h expected 1", bus_if.SRAM_start); end
        rst = 1'b1;
        step();
        bus_if.req1 = 1'b0;
        vectors++; if (bus_if.SRAM_start !== 1'b0) begin miscompares++; $display("[TB] FAIL rma_start: got %h expected 0", bus_if.SRAM_start); end
        vectors++; if (bus_if.ack1 !== 1'b0) begin miscompares++; $display("[TB] FAIL rma_ack1: got %h expected 0", bus_if.ack1); end
        vectors++; if (bus_if.rdata1 !== 16'h0) begin miscompares++; $display("[TB] FAIL rma_rdata1: got %h expected 0", bus_if.rdata1); end
        vectors++; if (bus_if.busy !== 1'b0 || bus_if.grant_id !== 1'b0) begin miscompares++; $display("[TB] FAIL rma_state: got %h/%h expected 0/0", bus_if.busy, bus_if.grant_id); end
        step();
        vectors++; if (bus_if.ack1 !== 1'b0 || bus_if.rdata1 !== 16'h0) begin miscompares++; $display("[TB] FAIL rma_later: got %h/%h expected 0/0000", bus_if.ack1, bus_if.rdata1); end
        rst = 1'b0;
        step();
        vectors++; if (bus_if.SRAM_start !== 1'b0) begin miscompares++; $display("[TB] FAIL rma_idle: got %h expected 0", bus_if.SRAM_start); end
    endtask

    // One-cycle req0 pulse: full access, one ack, no second grant.
    task automatic test_req_dropped();
        int acks;
        acks = 0;
        bus_if.req0 = 1'b1; bus_if.we_n0 = 1'b0; bus_if.addr0 = 20'h00003; bus_if.wdata0 = 16'h1111;
        step();
        bus_if.req0 = 1'b0;
        vectors++; if (bus_if.SRAM_start !== 1'b1 || bus_if.grant_id !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_grant: got %h/%h expected 1/0", bus_if.SRAM_start, bus_if.grant_id); end
        step();
        vectors++; if (bus_if.SRAM_start !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_start_c2: got %h expected 1", bus_if.SRAM_start); end
        step();
        vectors++; if (bus_if.ack0 !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_ack0: got %h expected 1", bus_if.ack0); end
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus_if.ack0 === 1'b1) acks++;
            if (bus_if.SRAM_start === 1'b1) acks += 10;
        end
        vectors++; if (acks !== 0) begin miscompares++; $display("[TB] FAIL drop_no_regrant: got %0d extra events expected 0", acks); end
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_busy: got %h expected 0", bus_if.busy); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
        bus_if.we_n0 = 1'b1; bus_if.we_n1 = 1'b1;
        bus_if.addr0 = '0; bus_if.addr1 = '0;
        bus_if.wdata0 = '0; bus_if.wdata1 = '0;
        bus_if.SRAM_read_data = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_reset_mid_access();
        test_req_dropped();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
